tri_view_cull: RTL

// - Consumer stage directly downstream of cs_stack: pops Triangle3D entries, classifies each against the view volume, and forwards the survivors.
// - A triangle is rejected if all 3 vertices lie outside the same plane; otherwise it goes out on a valid/ready port.
// - The output carries a clip_needed flag and a 6-bit plane mask for the downstream clipper.
// - Keeps saturating pass/cull statistics.

---
 rtl/tri_view_cull.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tri_view_cull.sv
// View-volume culling stage downstream of cs_stack.
// Pops one triangle at a time, rejects it if every vertex is outside one common plane,
// otherwise forwards it with clip hints. Keeps saturating pass/cull statistics.
module tri_view_cull #(
    parameter int          XMIN    = -100,
    parameter int          XMAX    = 100,
    parameter int          YMIN    = -100,
    parameter int          YMAX    = 100,
    parameter int          ZNEAR   = 1,
    parameter int          ZFAR    = 1000,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned COORD_W = 16,
    parameter int unsigned TRI_W   = 9 * COORD_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic [TRI_W-1:0] stk_tri,
    input  logic             stk_empty,
    output logic             stk_pop,
    output logic [TRI_W-1:0] out_tri,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_clip_needed,
    output logic [5:0]       out_clip_mask,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] cull_cnt,
    output logic             busy
);

    // Triangle layout: {p, q, r}, each vertex {x, y, z}, signed COORD_W-bit coordinates.
    localparam int unsigned V_W = 3 * COORD_W;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StOut
    } state_e;

    state_e           state_q, state_d;
    logic [TRI_W-1:0] tri_q;
    logic             load_tri;
    logic             load_out;
    logic             inc_pass;
    logic             inc_cull;

    logic [5:0] code_p, code_q, code_r;
    logic [5:0] and_c, or_c;

    // Bits {z>ZFAR, z<ZNEAR, y>YMAX, y<YMIN, x>XMAX, x<XMIN}; a value on a bound is inside.
    function automatic logic [5:0] outcode(input logic [V_W-1:0] v);
        int x, y, z;
        x = int'($signed(v[V_W-1 -: COORD_W]));
        y = int'($signed(v[2*COORD_W-1 -: COORD_W]));
        z = int'($signed(v[COORD_W-1:0]));
        return {z > ZFAR, z < ZNEAR, y > YMAX, y < YMIN, x > XMAX, x < XMIN};
    endfunction

    always_comb begin
        code_p = outcode(tri_q[TRI_W-1 -: V_W]);
        code_q = outcode(tri_q[2*V_W-1 -: V_W]);
        code_r = outcode(tri_q[V_W-1:0]);
        and_c  = code_p & code_q & code_r;
        or_c   = code_p | code_q | code_r;
    end

    // Next-state and strobes; stk_pop is Mealy on enable/stk_empty while idle.
    always_comb begin
        state_d  = state_q;
        stk_pop  = 1'b0;
        load_tri = 1'b0;
        load_out = 1'b0;
        inc_pass = 1'b0;
        inc_cull = 1'b0;
        unique case (state_q)
            StIdle: begin
                stk_pop = enable & ~stk_empty;
                if (stk_pop) begin
                    load_tri = 1'b1;
                    state_d  = StEval;
                end
            end
            StEval: begin
                if (|and_c) begin
                    inc_cull = 1'b1;
                    state_d  = StIdle;
                end else begin
                    load_out = 1'b1;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    inc_pass = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tri_q <= '0;
        end else if (load_tri) begin
            tri_q <= stk_tri;
        end
    end

    // Output register only changes on the EVAL->OUT transition, so it is stable while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_tri         <= '0;
            out_clip_mask   <= '0;
            out_clip_needed <= 1'b0;
        end else if (load_out) begin
            out_tri         <= tri_q;
            out_clip_mask   <= or_c;
            out_clip_needed <= |or_c;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pass_cnt <= '0;
            cull_cnt <= '0;
        end else begin
            if (inc_pass && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
            if (inc_cull && (cull_cnt != '1)) begin
                cull_cnt <= cull_cnt + 1'b1;
            end
        end
    end

    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);

    a_pop_only_idle : assert property (@(posedge clk) disable iff (!n_rst)
        stk_pop |-> (state_q == StIdle));

    a_out_stable : assert property (@(posedge clk) disable iff (!n_rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_tri) && $stable(out_clip_mask)));

endmodule
